// File: rtl/mon_serial_rx_pkg.sv
// Shared definitions for the serial monitor receiver: FSM states and default framing.
package mon_serial_rx_pkg;

   localparam int unsigned DEF_CLKS_PER_BIT = 8;
   localparam int unsigned DEF_DATA_W       = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } rx_state_t;

endpackage

// File: rtl/mon_serial_rx_sync.sv
// Two-flop synchronizer for the raw serial line; presets to idle-high on reset.
module mon_serial_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/mon_serial_rx.sv
// Serial frame receiver: start/data/stop FSM with mid-bit sampling, one-word
// valid/ready output register, one-cycle frame error pulse and sticky overrun.
module mon_serial_rx
   import mon_serial_rx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_W       = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DATA_W - 1);

   logic w_rx_s;

   rx_state_t         r_state, w_state_n;
   logic [TW-1:0]     r_timer, w_timer_n;
   logic [IW-1:0]     r_idx, w_idx_n;
   logic [DATA_W-1:0] r_shift, w_shift_n;
   logic [DATA_W:0]   w_shift_in;
   logic              w_stop_sample;

   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_frame_err;
   logic              r_overrun;
   logic              w_good;
   logic              w_bad;
   logic              w_hs;

   mon_serial_rx_sync u_sync (
      .clk (clk),
      .rst (reset),
      .i_d (rx_in),
      .o_q (w_rx_s)
   );

   // New bit enters at the MSB; after DATA_W shifts the first bit sits at the LSB.
   assign w_shift_in = {w_rx_s, r_shift};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_timer <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_n;
         r_timer <= w_timer_n;
         r_idx   <= w_idx_n;
         r_shift <= w_shift_n;
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_timer_n     = r_timer;
      w_idx_n       = r_idx;
      w_shift_n     = r_shift;
      w_stop_sample = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_rx_s) begin
               w_timer_n = '0;
               w_state_n = ST_START;
            end
         end
         ST_START: begin
            if (r_timer == T_HALF) begin
               if (!w_rx_s) begin
                  w_timer_n = '0;
                  w_idx_n   = '0;
                  w_state_n = ST_DATA;
               end else begin
                  w_state_n = ST_IDLE;
               end
            end else begin
               w_timer_n = r_timer + 1'b1;
            end
         end
         ST_DATA: begin
            if (r_timer == T_LAST) begin
               w_timer_n = '0;
               w_shift_n = w_shift_in[DATA_W:1];
               if (r_idx == I_LAST) begin
                  w_state_n = ST_STOP;
               end else begin
                  w_idx_n = r_idx + 1'b1;
               end
            end else begin
               w_timer_n = r_timer + 1'b1;
            end
         end
         ST_STOP: begin
            if (r_timer == T_LAST) begin
               w_stop_sample = 1'b1;
               w_timer_n     = '0;
               w_state_n     = ST_IDLE;
            end else begin
               w_timer_n = r_timer + 1'b1;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   assign w_good = w_stop_sample & w_rx_s;
   assign w_bad  = w_stop_sample & ~w_rx_s;
   assign w_hs   = r_out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= w_bad;
         // A word consumed in the same cycle frees the register for the new frame.
         if (w_good && (!r_out_valid || w_hs)) begin
            r_out_data  <= r_shift;
            r_out_valid <= 1'b1;
         end else if (w_hs) begin
            r_out_valid <= 1'b0;
         end
         if (w_good && r_out_valid && !out_ready) begin
            r_overrun <= 1'b1;
         end else if (overrun_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: doc/mon_serial_rx.md
MON_SERIAL_RX -- requirements
Module: mon_serial_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clk cycles per serial bit period (legal range 4..255).
REQ-002 SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal range 1..32).
REQ-003 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_in  input  1  raw asynchronous serial line, idle high.
REQ-006 SHALL have port out_data  output  DATA_W  last received payload, LSB received first.
REQ-007 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-008 SHALL have port out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse when a stop bit samples low.
REQ-010 SHALL have port overrun  output  1  sticky: a frame completed while out_valid was high.
REQ-011 SHALL have port overrun_clr  input  1  clears overrun.

Function
REQ-012 SHALL route rx_in through a two-flop posedge synchronizer; all decisions use the synchronized line (rx_s), adding 2 cycles of latency.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: on rx_s low SHALL clear the bit-timer and enter START.
REQ-015 START: when the bit-timer reaches CLKS_PER_BIT/2-1 (integer division), SHALL sample rx_s; low -> clear the timer and enter DATA with bit index 0; high -> false start, return to IDLE, no output.
REQ-016 DATA: the bit-timer SHALL count 0..CLKS_PER_BIT-1 and wrap; at CLKS_PER_BIT-1 it SHALL shift rx_s into the shift register MSB-side (LSB-first framing), advancing the bit index; after bit DATA_W-1 it SHALL enter STOP.
REQ-017 STOP: at timer CLKS_PER_BIT-1 SHALL sample rx_s; high -> frame good; low -> pulse frame_err for exactly one cycle and discard the payload; either way enter IDLE next cycle.
REQ-018 On a good frame with out_valid low, SHALL load out_data and assert out_valid on the cycle after the stop sample.
REQ-019 On a good frame with out_valid high and out_ready low, SHALL keep the old out_data, drop the new word, and set overrun.
REQ-020 On a good frame in the same cycle as a handshake (out_valid && out_ready), SHALL load the new word and keep out_valid high; overrun is not set.
REQ-021 out_valid SHALL deassert the cycle after out_valid && out_ready with no simultaneous new word; out_data SHALL be stable while out_valid is high.
REQ-022 overrun_clr SHALL clear overrun; if a set and a clear coincide, set wins.
REQ-023 The receiver SHALL be back in IDLE and able to detect a start edge on the first cycle after leaving STOP (back-to-back frames with a one-bit stop).
REQ-024 Timer and index widths SHALL be sized with $clog2 of CLKS_PER_BIT and DATA_W; no wrap beyond the terminal counts.

Reset
REQ-025 While reset is high: state=IDLE, timer=0, index=0, shift register=0, out_data=0, out_valid=0, frame_err=0, overrun=0, synchronizer flops=1 (idle).
REQ-026 Reset mid-frame SHALL abandon the frame without asserting any output; after release, reception restarts only on a fresh low on rx_s.

Structure
REQ-027 The state encodings and default CLKS_PER_BIT/DATA_W SHALL live in the shared definitions include nextasic_defs.vh.
REQ-028 The input synchronizer SHALL be an instance of the existing FF2SyncP, extended with reset preset to 1, or a local equivalent with the same 2-flop behaviour.
REQ-029 There SHALL be no other sub-modules; FSM, timer and output register are in one module.

Verification (CLKS_PER_BIT=8, DATA_W=8)
REQ-030 Frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop high) with out_ready=1 -> out_valid for 1 cycle, out_data=0xA5, frame_err=0, overrun=0.
REQ-031 2-cycle low glitch on idle line -> START rejects it at the mid-bit sample; no out_valid, no frame_err.
REQ-032 Frame 0x3C with stop bit driven low -> frame_err pulses 1 cycle, out_valid stays 0, next good frame 0x81 is received correctly.
REQ-033 out_ready=0, frames 0x11 then 0x22 back-to-back -> out_data stays 0x11, overrun=1; pulse overrun_clr -> overrun=0.
REQ-034 Assert reset during DATA bit 4 of frame 0xFF, release, then send 0x5A -> no output for 0xFF, out_data=0x5A.
REQ-035 Handshake in the same cycle a new frame 0x77 completes -> out_valid stays 1, out_data=0x77, overrun=0.
